// File: rtl/led_blink_sequencer.sv
// LED pattern sequencer driven by timer ticks: off, solid, continuous blink, or N-blink burst + gap + done.
// Optional PWM dimming of lit phases when LED_PWM_DIM_EN is defined.
module led_blink_sequencer #(
  parameter int ON_TICKS  = 2,
  parameter int OFF_TICKS = 2,
  parameter int GAP_TICKS = 8,
  parameter int CNT_W     = 4,
  parameter int PH_W      = 8,
  parameter int PWM_W     = 4,
  parameter int PWM_DUTY  = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_tick_in,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic [1:0]       i_cfg_mode,
  input  logic [CNT_W-1:0] i_cfg_blinks,
  output logic             o_led,
  output logic             o_busy,
  output logic             o_done
);

  // state    | meaning
  // S_IDLE   | LED off, waiting for config
  // S_SOLID  | LED steadily on
  // S_ON_PH  | lit half of a blink
  // S_OFF_PH | dark half of a blink
  // S_GAP    | quiet period after the last burst blink
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SOLID  = 3'd1,
    S_ON_PH  = 3'd2,
    S_OFF_PH = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [PH_W-1:0]  r_phase, w_phase_nxt;
  logic [CNT_W-1:0] r_bcnt, w_bcnt_nxt;
  logic [CNT_W-1:0] r_nblk, w_nblk_nxt;
  logic             r_burst, w_burst_nxt;
  logic             r_led, r_busy, r_done, r_ready;
  logic             w_done_nxt, w_ready_nxt, w_on_nxt, w_led_nxt, w_accept;

  assign w_accept = i_cfg_valid & r_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_bcnt_nxt  = r_bcnt;
    w_nblk_nxt  = r_nblk;
    w_burst_nxt = r_burst;
    w_done_nxt  = 1'b0;
    if (w_accept) begin
      // accept has priority: any coincident tick is dropped
      w_phase_nxt = '0;
      w_bcnt_nxt  = '0;
      w_burst_nxt = 1'b0;
      case (i_cfg_mode)
        2'd0: w_state_nxt = S_IDLE;
        2'd1: w_state_nxt = S_SOLID;
        2'd2: w_state_nxt = S_ON_PH;
        default: begin
          if (i_cfg_blinks != '0) begin
            w_state_nxt = S_ON_PH;
            w_burst_nxt = 1'b1;
            w_nblk_nxt  = i_cfg_blinks;
          end else begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      endcase
    end else if (i_tick_in) begin
      case (r_state)
        S_ON_PH: begin
          if (r_phase == PH_W'(ON_TICKS - 1)) begin
            w_phase_nxt = '0;
            w_state_nxt = S_OFF_PH;
            if (r_burst) w_bcnt_nxt = r_bcnt + CNT_W'(1);
          end else begin
            w_phase_nxt = r_phase + PH_W'(1);
          end
        end
        S_OFF_PH: begin
          if (r_phase == PH_W'(OFF_TICKS - 1)) begin
            w_phase_nxt = '0;
            w_state_nxt = (r_burst && (r_bcnt == r_nblk)) ? S_GAP : S_ON_PH;
          end else begin
            w_phase_nxt = r_phase + PH_W'(1);
          end
        end
        S_GAP: begin
          if (r_phase == PH_W'(GAP_TICKS - 1)) begin
            w_phase_nxt = '0;
            w_state_nxt = S_IDLE;
            w_burst_nxt = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_phase_nxt = r_phase + PH_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign w_on_nxt    = (w_state_nxt == S_SOLID) || (w_state_nxt == S_ON_PH);
  assign w_ready_nxt = (w_state_nxt == S_IDLE) || (w_state_nxt == S_SOLID) ||
                       (((w_state_nxt == S_ON_PH) || (w_state_nxt == S_OFF_PH)) && !w_burst_nxt);

`ifdef LED_PWM_DIM_EN
  logic [PWM_W-1:0] r_pwm;
  logic [PWM_W-1:0] w_pwm_nxt;

  assign w_pwm_nxt = r_pwm + PWM_W'(1);
  assign w_led_nxt = w_on_nxt & (32'(w_pwm_nxt) < $unsigned(PWM_DUTY));

  always_ff @(posedge i_clk) begin
    if (i_rst) r_pwm <= '0;
    else       r_pwm <= w_pwm_nxt;
  end
`else
  assign w_led_nxt = w_on_nxt;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_phase <= '0;
      r_bcnt  <= '0;
      r_nblk  <= '0;
      r_burst <= 1'b0;
      r_led   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_nblk  <= w_nblk_nxt;
      r_burst <= w_burst_nxt;
      r_led   <= w_led_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= w_done_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  assign o_led       = r_led;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_cfg_ready = r_ready;

endmodule
